spi_flash_arb: RTL and testbench
================================

SPI_FLASH_ARB -- requirements
Module: spi_flash_arb

Interface
REQ-001 SHALL have parameter CS_GAP, default 4, meaning the number of clk cycles cs_n stays high between transactions (legal 1..15).
REQ-002 SHALL have parameter MAX_RD, default 8, meaning the maximum number of read bytes per transaction (legal 1..15).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have ports req_a and req_b, inputs, 1 bit each: requester transaction request, held until the matching done pulse.
REQ-006 SHALL have ports cmd_a and cmd_b, inputs, 8 bits each: the opcode to send, sampled at grant.
REQ-007 SHALL have ports len_a and len_b, inputs, 4 bits each: the read byte count, sampled at grant; 0 means command only.
REQ-008 SHALL have ports gnt_a and gnt_b, outputs, 1 bit each: one-cycle grant pulse.
REQ-009 SHALL have ports done_a and done_b, outputs, 1 bit each: one-cycle completion pulse.
REQ-010 SHALL have port rd_valid, output, 1 bit: read byte strobe, routed by owner.
REQ-011 SHALL have port rd_owner, output, 1 bit: owner of the strobe; 0 = A, 1 = B.
REQ-012 SHALL have port rd_byte, output, 8 bits: received byte, valid with rd_valid.
REQ-013 SHALL have port eng_start, output, 1 bit: one-cycle request to the byte engine to shift one byte.
REQ-014 SHALL have port eng_tx, output, 8 bits: byte to transmit, valid with eng_start.
REQ-015 SHALL have port eng_done, input, 1 bit: byte engine finished its byte; eng_rx is valid.
REQ-016 SHALL have port eng_rx, input, 8 bits: byte received by the engine.
REQ-017 SHALL have port cs_n, output, 1 bit: flash chip select, active low, owned by this block.
REQ-018 SHALL have port err, output, 1 bit: sticky timeout flag (see Configuration).

Function
REQ-019 SHALL implement the FSM states IDLE, ARB, CMD, READ and GAP.
REQ-020 IDLE SHALL go to ARB when req_a or req_b is high.
REQ-021 In ARB, SHALL pulse one gnt, latch that requester's cmd and len (len clamped to MAX_RD), drive cs_n low, and go to CMD next cycle.
REQ-022 Arbitration SHALL be round-robin: on a simultaneous request, grant the requester not granted last; the pointer resets to favour A.
REQ-023 In CMD, SHALL pulse eng_start once with eng_tx equal to the latched cmd, then wait for eng_done.
REQ-024 On eng_done in CMD, SHALL go to READ if len > 0, otherwise to GAP.
REQ-025 In READ, SHALL pulse eng_start with eng_tx = 8'h00 for each byte.
REQ-026 In READ, on each eng_done, SHALL assert rd_valid for one cycle with rd_byte = eng_rx and rd_owner = owner, and decrement the byte counter.
REQ-027 In READ, after the last byte SHALL go to GAP.
REQ-028 eng_start SHALL never assert while an engine byte is outstanding; at most one byte is in flight.
REQ-029 In GAP, SHALL drive cs_n high and pulse done for the owner on the first GAP cycle.
REQ-030 SHALL hold GAP for exactly CS_GAP cycles, then go to IDLE.
REQ-031 A requester dropping req mid-transaction SHALL NOT abort it.
REQ-032 A request asserted during GAP SHALL be granted no earlier than the first ARB cycle after GAP.
REQ-033 Latency SHALL be: req high in IDLE to gnt = 2 cycles; eng_done of last byte to done = 1 cycle.
REQ-034 An eng_done outside CMD/READ SHALL be ignored.

Reset
REQ-035 rst asserted SHALL immediately force state IDLE, cs_n = 1, and all pulses (gnt, done, rd_valid, eng_start) to 0.
REQ-036 rst asserted SHALL force eng_tx, rd_byte and rd_owner to 0, clear err, and set the round-robin pointer to A.
REQ-037 Reset mid-transaction SHALL drop cs_n without a done pulse.

Configuration
REQ-038 With SPI_ARB_TIMEOUT_EN defined, SHALL abort the transaction if eng_done is absent for 1024 cycles after eng_start.
REQ-039 On a timeout abort, SHALL go to GAP, pulse done for the owner, and set err until reset.
REQ-040 Without SPI_ARB_TIMEOUT_EN, SHALL omit the watchdog logic and tie err to 0.

Structure
REQ-041 Package spi_flash_pkg SHALL hold the FSM state encoding, the dummy byte 8'h00, the read-ID opcode 8'h9F and the timeout limit.
REQ-042 Round-robin selection SHALL be a sub-module spi_rr_arb (2 requests, pointer, one-hot grant).

Verification
REQ-043 A bench SHALL cover: req_a with cmd_a = 8'h9F, len_a = 3, engine returning EF,40,18 -> one eng_tx 9F, three 00, rd_valid×3 with owner 0 and bytes EF,40,18, done_a, cs_n high 4 cycles.
REQ-044 A bench SHALL cover: req_a and req_b rising the same cycle from reset -> gnt_a first, then gnt_b after A's GAP.
REQ-045 A bench SHALL cover: req_b with len_b = 0, cmd 8'h06 -> single engine byte, no rd_valid, done_b.
REQ-046 A bench SHALL cover: len_a = 15 with MAX_RD = 8 -> exactly 8 read bytes.
REQ-047 A bench SHALL cover: rst pulsed during READ -> cs_n = 1 the same cycle, no done, next request served normally.
REQ-048 A bench SHALL cover: SPI_ARB_TIMEOUT_EN defined with the engine never answering -> done after 1024 cycles, err = 1.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash arbiter: FSM state encoding, fixed bytes,
// watchdog limit and the read-length clamp helper.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_CMD,
    ST_READ,
    ST_GAP
  } arb_state_t;

  localparam logic [7:0] DUMMY_BYTE    = 8'h00;
  localparam logic [7:0] OP_READ_ID    = 8'h9F;
  localparam int         TIMEOUT_LIMIT = 1024;
  localparam int         TIMEOUT_W     = $clog2(TIMEOUT_LIMIT);

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/spi_rr_arb.sv
// Two-way round-robin arbiter with a one-hot grant; a tie goes to whichever
// requester was not granted last, and reset favours A.
module spi_rr_arb
  import spi_flash_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant
);

  logic r_ptr_b;

  always_comb begin
    o_grant = 2'b00;
    if (i_req[0] && !(i_req[1] && r_ptr_b)) begin
      o_grant = 2'b01;
    end else if (i_req[1]) begin
      o_grant = 2'b10;
    end
  end

  // After granting A the next tie belongs to B, and vice versa.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr_b <= 1'b0;
    end else if (i_update && (o_grant != 2'b00)) begin
      r_ptr_b <= o_grant[0];
    end
  end

endmodule

// File: rtl/spi_flash_arb.sv
// Arbitrates two requesters onto one SPI flash byte engine and owns cs_n.
// Define SPI_ARB_TIMEOUT_EN to add the eng_done watchdog and the sticky err flag.
module spi_flash_arb
  import spi_flash_pkg::*;
#(
  parameter int CS_GAP = 4,
  parameter int MAX_RD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic [3:0] len_a,
  input  logic [3:0] len_b,
  output logic       gnt_a,
  output logic       gnt_b,
  output logic       done_a,
  output logic       done_b,
  output logic       rd_valid,
  output logic       rd_owner,
  output logic [7:0] rd_byte,
  output logic       eng_start,
  output logic [7:0] eng_tx,
  input  logic       eng_done,
  input  logic [7:0] eng_rx,
  output logic       cs_n,
  output logic       err
);

  localparam logic [3:0] GAP_LOAD = 4'(CS_GAP - 1);
  localparam logic [3:0] MAX_LEN  = 4'(MAX_RD);

  arb_state_t r_state, w_state_next;

  logic [3:0] r_gap_cnt, w_gap_next;
  logic [3:0] r_len, w_len_next;
  logic       r_owner, w_owner_next;
  logic       r_inflight, w_inflight_next;
  logic       r_gnt_a, r_gnt_b, r_done_a, r_done_b;
  logic       r_rd_valid, r_rd_owner, r_eng_start, r_cs_n;
  logic [7:0] r_rd_byte, r_eng_tx;
  logic       w_gnt_a, w_gnt_b, w_done_a, w_done_b;
  logic       w_rd_valid, w_rd_owner, w_eng_start, w_cs_n;
  logic [7:0] w_rd_byte, w_eng_tx;
  logic [1:0] w_grant;
  logic       w_eng_ack, w_timeout, w_to_gap;

  spi_rr_arb u_rr_arb (
    .clk      (clk),
    .rst      (rst),
    .i_req    ({req_b, req_a}),
    .i_update (r_state == ST_ARB),
    .o_grant  (w_grant)
  );

  // Only an answer to a byte we actually launched counts; stray eng_done is ignored.
  assign w_eng_ack = r_inflight && eng_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_gap_next      = r_gap_cnt;
    w_len_next      = r_len;
    w_owner_next    = r_owner;
    w_inflight_next = r_inflight;
    w_gnt_a         = 1'b0;
    w_gnt_b         = 1'b0;
    w_done_a        = 1'b0;
    w_done_b        = 1'b0;
    w_rd_valid      = 1'b0;
    w_rd_byte       = r_rd_byte;
    w_rd_owner      = r_rd_owner;
    w_eng_start     = 1'b0;
    w_eng_tx        = r_eng_tx;
    w_cs_n          = r_cs_n;
    w_to_gap        = 1'b0;
    if (w_eng_ack) begin
      w_inflight_next = 1'b0;
    end
    unique case (r_state)
      ST_IDLE: begin
        if (req_a || req_b) begin
          w_state_next = ST_ARB;
        end
      end
      ST_ARB: begin
        if (w_grant != 2'b00) begin
          w_owner_next    = w_grant[1];
          w_rd_owner      = w_grant[1];
          w_gnt_a         = w_grant[0];
          w_gnt_b         = w_grant[1];
          w_len_next      = clamp_len(w_grant[1] ? len_b : len_a, MAX_LEN);
          w_eng_tx        = w_grant[1] ? cmd_b : cmd_a;
          w_eng_start     = 1'b1;
          w_inflight_next = 1'b1;
          w_cs_n          = 1'b0;
          w_state_next    = ST_CMD;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (w_eng_ack) begin
          if (r_len != 4'd0) begin
            w_eng_start     = 1'b1;
            w_eng_tx        = DUMMY_BYTE;
            w_inflight_next = 1'b1;
            w_state_next    = ST_READ;
          end else begin
            w_to_gap = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (w_eng_ack) begin
          w_rd_valid = 1'b1;
          w_rd_byte  = eng_rx;
          w_len_next = r_len - 4'd1;
          if (r_len == 4'd1) begin
            w_to_gap = 1'b1;
          end else begin
            w_eng_start     = 1'b1;
            w_eng_tx        = DUMMY_BYTE;
            w_inflight_next = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_gap_next = r_gap_cnt - 4'd1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_to_gap        = 1'b1;
      w_inflight_next = 1'b0;
    end
    // Normal completion and watchdog abort leave through the same door.
    if (w_to_gap) begin
      w_state_next = ST_GAP;
      w_cs_n       = 1'b1;
      w_done_a     = ~r_owner;
      w_done_b     = r_owner;
      w_gap_next   = GAP_LOAD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt   <= 4'd0;
      r_len       <= 4'd0;
      r_owner     <= 1'b0;
      r_inflight  <= 1'b0;
      r_gnt_a     <= 1'b0;
      r_gnt_b     <= 1'b0;
      r_done_a    <= 1'b0;
      r_done_b    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_owner  <= 1'b0;
      r_rd_byte   <= 8'h00;
      r_eng_start <= 1'b0;
      r_eng_tx    <= 8'h00;
      r_cs_n      <= 1'b1;
    end else begin
      r_gap_cnt   <= w_gap_next;
      r_len       <= w_len_next;
      r_owner     <= w_owner_next;
      r_inflight  <= w_inflight_next;
      r_gnt_a     <= w_gnt_a;
      r_gnt_b     <= w_gnt_b;
      r_done_a    <= w_done_a;
      r_done_b    <= w_done_b;
      r_rd_valid  <= w_rd_valid;
      r_rd_owner  <= w_rd_owner;
      r_rd_byte   <= w_rd_byte;
      r_eng_start <= w_eng_start;
      r_eng_tx    <= w_eng_tx;
      r_cs_n      <= w_cs_n;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wd;
  logic                 r_err;

  assign w_timeout = r_inflight && !eng_done && (r_wd == TIMEOUT_W'(TIMEOUT_LIMIT - 1));

  // The watchdog restarts with every launched byte and idles when nothing is outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      r_wd  <= (w_eng_start || !r_inflight) ? '0 : r_wd + 1'b1;
      r_err <= r_err | w_timeout;
    end
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  assign gnt_a     = r_gnt_a;
  assign gnt_b     = r_gnt_b;
  assign done_a    = r_done_a;
  assign done_b    = r_done_b;
  assign rd_valid  = r_rd_valid;
  assign rd_owner  = r_rd_owner;
  assign rd_byte   = r_rd_byte;
  assign eng_start = r_eng_start;
  assign eng_tx    = r_eng_tx;
  assign cs_n      = r_cs_n;

endmodule

// File: tb/tb_spi_flash_arb.sv
// Scoreboard bench for spi_flash_arb: a transaction-level model predicts grant order,
// engine bytes, read bytes and completion timing; a bench-side engine answers eng_start.
module tb_spi_flash_arb;

  localparam int CS_GAP      = 4;
  localparam int MAX_RD      = 8;
  localparam int TIMEOUT_CYC = 1024;

  logic       clk, rst;
  logic       req_a, req_b;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] len_a, len_b;
  logic       gnt_a, gnt_b, done_a, done_b;
  logic       rd_valid, rd_owner;
  logic [7:0] rd_byte;
  logic       eng_start;
  logic [7:0] eng_tx;
  logic       eng_done;
  logic [7:0] eng_rx;
  logic       cs_n, err;

  spi_flash_arb #(.CS_GAP(CS_GAP), .MAX_RD(MAX_RD)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .len_a(len_a), .len_b(len_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .done_a(done_a), .done_b(done_b),
    .rd_valid(rd_valid), .rd_owner(rd_owner), .rd_byte(rd_byte),
    .eng_start(eng_start), .eng_tx(eng_tx),
    .eng_done(eng_done), .eng_rx(eng_rx),
    .cs_n(cs_n), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    bit isDone;
    bit owner;
    int absCycle;
    bit relGap;
    bit timeout;
  } txnEv_t;

  typedef struct {
    bit         owner;
    logic [7:0] data;
  } rdEv_t;

  typedef struct {
    logic [7:0] data;
    bit         last;
  } engResp_t;

  txnEv_t     expTxn[$];
  logic [7:0] expTx[$];
  rdEv_t      expRd[$];
  engResp_t   engQ[$];
  logic [7:0] directedData[$];

  int passCount  = 0;
  int checkCount = 0;

  // Round-robin model: after reset the tie goes to A, so "last winner" starts as B.
  bit modelLastB = 1'b1;

  int       lastDoneCycle   = 0;
  int       engLastAckCycle = 0;
  int       engStartCycle   = 0;
  int       engWait         = 0;
  bit       engBusy         = 1'b0;
  bit       engMute         = 1'b0;
  engResp_t engCur;
  int       csHigh          = 0;
  bit       haveDone        = 1'b0;
  txnEv_t   monEv;
  rdEv_t    monRd;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Predicts one whole transaction for owner o and queues everything it should produce.
  task automatic pushTxn(input bit o, input logic [7:0] cmd, input logic [3:0] len, input int absCycle);
    int         n;
    txnEv_t     ev;
    rdEv_t      rd;
    engResp_t   er;
    logic [7:0] d;
    n = (int'(len) > MAX_RD) ? MAX_RD : int'(len);
    ev.isDone = 1'b0; ev.owner = o; ev.absCycle = absCycle; ev.relGap = (absCycle < 0); ev.timeout = 1'b0;
    expTxn.push_back(ev);
    expTx.push_back(cmd);
    er.data = 8'($urandom); er.last = (n == 0);
    engQ.push_back(er);
    for (int i = 0; i < n; i++) begin
      d = (directedData.size() > 0) ? directedData.pop_front() : 8'($urandom);
      expTx.push_back(8'h00);
      rd.owner = o; rd.data = d;
      expRd.push_back(rd);
      er.data = d; er.last = (i == n - 1);
      engQ.push_back(er);
    end
    ev.isDone = 1'b1; ev.absCycle = 0; ev.relGap = 1'b0;
    expTxn.push_back(ev);
  endtask

  task automatic checkResetState();
    checkOutput("rstCsN", cs_n, 1);
    checkOutput("rstGntA", gnt_a, 0);
    checkOutput("rstGntB", gnt_b, 0);
    checkOutput("rstDoneA", done_a, 0);
    checkOutput("rstDoneB", done_b, 0);
    checkOutput("rstRdValid", rd_valid, 0);
    checkOutput("rstEngStart", eng_start, 0);
    checkOutput("rstEngTx", eng_tx, 0);
    checkOutput("rstRdByte", rd_byte, 0);
    checkOutput("rstRdOwner", rd_owner, 0);
    checkOutput("rstErr", err, 0);
  endtask

  task automatic applyReset();
    rst = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    #1;
    checkResetState();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    expTxn.delete();
    expTx.delete();
    expRd.delete();
    engQ.delete();
    modelLastB = 1'b1;
  endtask

  task automatic applyStimulus(input bit useA, input bit useB,
                               input logic [7:0] cA, input logic [7:0] cB,
                               input logic [3:0] lA, input logic [3:0] lB,
                               input bit dropA, input bit dropB);
    bit first;
    @(posedge clk);
    #1;
    cmd_a = cA; len_a = lA;
    cmd_b = cB; len_b = lB;
    if (useA && useB) begin
      first = modelLastB ? 1'b0 : 1'b1;
      pushTxn(first, first ? cB : cA, first ? lB : lA, cycle + 2);
      pushTxn(!first, first ? cA : cB, first ? lA : lB, -1);
      modelLastB = !first;
    end else begin
      pushTxn(useB, useB ? cB : cA, useB ? lB : lA, cycle + 2);
      modelLastB = useB;
    end
    req_a = useA;
    req_b = useB;
    for (int c = 0; c < 3000 && (req_a || req_b); c++) begin
      @(negedge clk);
      if ((gnt_a && dropA) || done_a) req_a = 1'b0;
      if ((gnt_b && dropB) || done_b) req_b = 1'b0;
    end
    if (req_a || req_b) begin
      checkOutput("reqServed", {30'd0, req_b, req_a}, 0);
      req_a = 1'b0;
      req_b = 1'b0;
    end
    for (int c = 0; c < 50 && expTxn.size() > 0; c++) @(negedge clk);
    checkOutput("txnDrained", expTxn.size(), 0);
    checkOutput("bytesDrained", expRd.size() + expTx.size(), 0);
    repeat (CS_GAP + 2) @(posedge clk);
  endtask

  // Bench-side byte engine: answers each eng_start after 1..4 cycles from engQ.
  initial begin
    eng_done = 1'b0;
    eng_rx   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      eng_rx   = 8'($urandom);
      if (rst) begin
        engBusy = 1'b0;
      end else if (engBusy) begin
        if (eng_start) checkOutput("oneByteInFlight", 1, 0);
        if (engWait == 0) begin
          eng_done = 1'b1;
          eng_rx   = engCur.data;
          engBusy  = 1'b0;
          if (engCur.last) engLastAckCycle = cycle;
        end else begin
          engWait--;
        end
      end else if (eng_start) begin
        engStartCycle = cycle;
        if (!engMute) begin
          if (engQ.size() == 0) begin
            checkOutput("engStartUnexpected", 1, 0);
            engCur.data = 8'h00;
            engCur.last = 1'b0;
          end else begin
            engCur = engQ.pop_front();
          end
          engBusy = 1'b1;
          engWait = $urandom_range(0, 3);
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    if (rst) begin
      csHigh   = 0;
      haveDone = 1'b0;
    end else begin
      if (cs_n) begin
        csHigh++;
      end else if (csHigh > 0) begin
        if (haveDone) checkOutput("csHighCycles", {31'd0, csHigh >= CS_GAP}, 1);
        csHigh = 0;
      end
      if (gnt_a || gnt_b) begin
        checkOutput("gntOneHot", {31'd0, gnt_a & gnt_b}, 0);
        if (expTxn.size() == 0 || expTxn[0].isDone) begin
          checkOutput("gntUnexpected", {30'd0, gnt_b, gnt_a}, 0);
        end else begin
          monEv = expTxn.pop_front();
          checkOutput("gntOwner", gnt_b, monEv.owner);
          checkOutput("gntCycle", cycle, monEv.relGap ? lastDoneCycle + CS_GAP + 2 : monEv.absCycle);
          checkOutput("csLowAtGnt", cs_n, 0);
        end
      end
      if (done_a || done_b) begin
        checkOutput("doneOneHot", {31'd0, done_a & done_b}, 0);
        if (expTxn.size() == 0 || !expTxn[0].isDone) begin
          checkOutput("doneUnexpected", {30'd0, done_b, done_a}, 0);
        end else begin
          monEv = expTxn.pop_front();
          checkOutput("doneOwner", done_b, monEv.owner);
          checkOutput("doneCycle", cycle, monEv.timeout ? engStartCycle + TIMEOUT_CYC : engLastAckCycle + 1);
          checkOutput("csHighAtDone", cs_n, 1);
        end
        lastDoneCycle = cycle;
        haveDone      = 1'b1;
        csHigh        = 1;
      end
      if (eng_start) begin
        checkOutput("csLowAtStart", cs_n, 0);
        if (expTx.size() == 0) checkOutput("engStartExtra", 1, 0);
        else                   checkOutput("engTx", eng_tx, expTx.pop_front());
      end
      if (rd_valid) begin
        if (expRd.size() == 0) begin
          checkOutput("rdUnexpected", 1, 0);
        end else begin
          monRd = expRd.pop_front();
          checkOutput("rdOwner", rd_owner, monRd.owner);
          checkOutput("rdByte", rd_byte, monRd.data);
        end
      end
    end
  end

  initial begin
    bit sawEvt;
    int mask;
    req_a = 1'b0; req_b = 1'b0;
    cmd_a = 8'h00; cmd_b = 8'h00;
    len_a = 4'd0;  len_b = 4'd0;
    applyReset();

    $display("[TB] simultaneous requests from reset");
    applyStimulus(1, 1, 8'h9F, 8'h05, 4'd2, 4'd1, 0, 0);

    $display("[TB] read-ID with three bytes");
    directedData.push_back(8'hEF);
    directedData.push_back(8'h40);
    directedData.push_back(8'h18);
    applyStimulus(1, 0, 8'h9F, 8'h00, 4'd3, 4'd0, 0, 0);

    $display("[TB] command-only on B");
    applyStimulus(0, 1, 8'h00, 8'h06, 4'd0, 4'd0, 0, 0);

    $display("[TB] length clamp");
    applyStimulus(1, 0, 8'h0B, 8'h00, 4'd15, 4'd0, 0, 0);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 25; t++) begin
      mask = $urandom_range(1, 3);
      applyStimulus(mask[0], mask[1], 8'($urandom), 8'($urandom),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during read");
    @(posedge clk);
    #1;
    cmd_b = 8'h03; len_b = 4'd8;
    pushTxn(1'b1, 8'h03, 4'd8, cycle + 2);
    req_b = 1'b1;
    sawEvt = 1'b0;
    for (int c = 0; c < 200 && !sawEvt; c++) begin
      @(negedge clk);
      sawEvt = rd_valid;
    end
    checkOutput("readReached", {31'd0, sawEvt}, 1);
    @(posedge clk);
    #2;
    applyReset();
    repeat (20) @(posedge clk);
    applyStimulus(0, 1, 8'h9F, 8'h9F, 4'd2, 4'd2, 0, 0);

`ifdef SPI_ARB_TIMEOUT_EN
    $display("[TB] engine never answers");
    engMute = 1'b1;
    @(posedge clk);
    #1;
    cmd_a = 8'h9F; len_a = 4'd2;
    monEv.isDone = 1'b0; monEv.owner = 1'b0; monEv.absCycle = cycle + 2; monEv.relGap = 1'b0; monEv.timeout = 1'b0;
    expTxn.push_back(monEv);
    expTx.push_back(8'h9F);
    monEv.isDone = 1'b1; monEv.absCycle = 0; monEv.timeout = 1'b1;
    expTxn.push_back(monEv);
    req_a = 1'b1;
    sawEvt = 1'b0;
    for (int c = 0; c < 1300 && !sawEvt; c++) begin
      @(negedge clk);
      sawEvt = done_a;
    end
    req_a = 1'b0;
    checkOutput("timeoutDone", {31'd0, sawEvt}, 1);
    @(negedge clk);
    checkOutput("errSet", err, 1);
    repeat (5) @(negedge clk);
    checkOutput("errSticky", err, 1);
    engMute = 1'b0;
    repeat (CS_GAP + 2) @(posedge clk);
    #1;
    applyReset();
`else
    checkOutput("errTiedLow", err, 0);
`endif

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
